// File: rtl/mem_unit.sv
// Memory responder for the thread unit interface: decodes the control word, steers
// byte/half/word data onto a word-addressed bus and splits word-crossing accesses.
package types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        UNIT_SEL_NONE,
        UNIT_SEL_ALU,
        UNIT_SEL_MEM,
        UNIT_SEL_CSR
    } unit_sel_t;

    localparam word_t MEM_CTRL_LB = 32'd1;
    localparam word_t MEM_CTRL_LH = 32'd2;
    localparam word_t MEM_CTRL_LW = 32'd3;
    localparam word_t MEM_CTRL_SB = 32'd4;
    localparam word_t MEM_CTRL_SH = 32'd5;
    localparam word_t MEM_CTRL_SW = 32'd6;
endpackage

module mem_unit
    import types_pkg::*;
#(
    parameter int unsigned BUS_AW   = 30,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  unit_sel_t         unit_sel,
    input  word_t             unit_in [3],
    output word_t             unit_out,
    output logic              unit_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t            state, state_n;
    word_t             ctrl_q, addr_q, data_q;
    word_t             ctrl_n, addr_n, data_n;
    logic [31:0]       rdata0_q, rdata0_n;
    logic              req_n, we_n;
    logic [BUS_AW-1:0] baddr_n;
    logic [3:0]        be_n;
    logic [31:0]       wdata_n;
    word_t             out_n;

    // In IDLE the live inputs feed the steering logic so word 0 can be issued next cycle.
    word_t             src_ctrl, src_addr, src_data;
    logic              dec_valid, dec_we;
    logic [3:0]        dec_mask;
    logic [1:0]        off;
    logic [4:0]        shamt;
    logic [63:0]       lanes;
    logic [7:0]        en;
    logic              split;
    logic [BUS_AW-1:0] word0, word1;
    logic [31:0]       rd_bits;
    logic [63:0]       rd_wide;
    logic [31:0]       rd_val;

    assign src_ctrl = (state == IDLE) ? unit_in[0] : ctrl_q;
    assign src_addr = (state == IDLE) ? unit_in[1] : addr_q;
    assign src_data = (state == IDLE) ? unit_in[2] : data_q;

    always_comb begin
        dec_valid = 1'b1;
        dec_we    = 1'b0;
        dec_mask  = 4'b0000;
        case (src_ctrl)
            MEM_CTRL_LB: dec_mask = 4'b0001;
            MEM_CTRL_LH: dec_mask = 4'b0011;
            MEM_CTRL_LW: dec_mask = 4'b1111;
            MEM_CTRL_SB: begin dec_mask = 4'b0001; dec_we = 1'b1; end
            MEM_CTRL_SH: begin dec_mask = 4'b0011; dec_we = 1'b1; end
            MEM_CTRL_SW: begin dec_mask = 4'b1111; dec_we = 1'b1; end
            default:     dec_valid = 1'b0;
        endcase
    end

    assign off     = SPLIT_EN ? src_addr[1:0] : 2'b00;
    assign shamt   = {off, 3'b000};
    assign lanes   = {32'b0, src_data} << shamt;
    assign en      = {4'b0000, dec_mask} << off;
    assign split   = |en[7:4];
    assign word0   = src_addr[BUS_AW+1:2];
    assign word1   = word0 + BUS_AW'(1);
    assign rd_bits = {{8{dec_mask[3]}}, {8{dec_mask[2]}}, {8{dec_mask[1]}}, {8{dec_mask[0]}}};
    assign rd_wide = (state == ACC1) ? {bus_rdata, rdata0_q} : {32'b0, bus_rdata};
    assign rd_val  = 32'(rd_wide >> shamt) & rd_bits;

    assign unit_ready = ((state == IDLE) && (unit_sel != UNIT_SEL_MEM)) || (state == DONE);

    always_comb begin
        state_n  = state;
        ctrl_n   = ctrl_q;
        addr_n   = addr_q;
        data_n   = data_q;
        rdata0_n = rdata0_q;
        req_n    = bus_req;
        we_n     = bus_we;
        baddr_n  = bus_addr;
        be_n     = bus_be;
        wdata_n  = bus_wdata;
        out_n    = unit_out;
        case (state)
            IDLE: begin
                if (unit_sel == UNIT_SEL_MEM) begin
                    ctrl_n = unit_in[0];
                    addr_n = unit_in[1];
                    data_n = unit_in[2];
                    if (dec_valid) begin
                        state_n = ACC0;
                        req_n   = 1'b1;
                        we_n    = dec_we;
                        baddr_n = word0;
                        be_n    = dec_we ? en[3:0] : 4'hF;
                        wdata_n = dec_we ? lanes[31:0] : 32'b0;
                    end else begin
                        state_n = DONE;
                        out_n   = '0;
                    end
                end
            end
            ACC0: begin
                if (bus_ack) begin
                    rdata0_n = bus_rdata;
                    if (split) begin
                        state_n = ACC1;
                        baddr_n = word1;
                        be_n    = dec_we ? en[7:4] : 4'hF;
                        wdata_n = dec_we ? lanes[63:32] : 32'b0;
                    end else begin
                        state_n = DONE;
                        req_n   = 1'b0;
                        out_n   = dec_we ? '0 : rd_val;
                    end
                end
            end
            ACC1: begin
                if (bus_ack) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    out_n   = dec_we ? '0 : rd_val;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata0_q  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            unit_out  <= '0;
        end else begin
            state     <= state_n;
            ctrl_q    <= ctrl_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            rdata0_q  <= rdata0_n;
            bus_req   <= req_n;
            bus_we    <= we_n;
            bus_addr  <= baddr_n;
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
            unit_out  <= out_n;
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: a byte-level reference model predicts bus
// transactions, read results and latency for directed and random accesses.
module tb_mem_unit;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    unit_sel_t   unit_sel;
    word_t       unit_in [3];
    word_t       unit_out;
    logic        unit_ready;
    logic        bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [bit [29:0]];

    always #5 clk = ~clk;

    mem_unit #(.BUS_AW(30), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .unit_sel(unit_sel), .unit_in(unit_in),
        .unit_out(unit_out), .unit_ready(unit_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    function automatic logic [31:0] get_word(input logic [29:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic void decode(input word_t c, output bit valid, output bit we, output int size);
        valid = 1'b1; we = 1'b0; size = 0;
        case (c)
            MEM_CTRL_LB: size = 1;
            MEM_CTRL_LH: size = 2;
            MEM_CTRL_LW: size = 4;
            MEM_CTRL_SB: begin size = 1; we = 1'b1; end
            MEM_CTRL_SH: begin size = 2; we = 1'b1; end
            MEM_CTRL_SW: begin size = 4; we = 1'b1; end
            default: valid = 1'b0;
        endcase
    endfunction

    task automatic do_access(input word_t ctrl, input word_t addr, input word_t data,
                             input int w0, input int w1, input string name);
        bit valid, we, done;
        int size, o, exp_n, exp_cycles, cyc, waitcnt, nobs, k, t, ln;
        logic [29:0] exp_addr [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] wv, bmask;
        word_t       exp_rd, got;
        logic [29:0] obs_addr [4];
        logic        obs_we [4];
        logic [3:0]  obs_be [4];
        logic [31:0] obs_wd [4];
        logic [29:0] s_addr;
        logic [3:0]  s_be;
        logic [31:0] s_wd;

        decode(ctrl, valid, we, size);
        o = int'(addr[1:0]);
        exp_addr[0] = addr[31:2];
        exp_addr[1] = addr[31:2] + 30'd1;
        exp_be[0] = we ? 4'h0 : 4'hF;
        exp_be[1] = exp_be[0];
        exp_wd[0] = '0;
        exp_wd[1] = '0;
        exp_rd = '0;
        got = '0;
        exp_n = !valid ? 0 : ((o + size > 4) ? 2 : 1);
        for (int i = 0; i < size; i++) begin
            k = o + i; t = k / 4; ln = k % 4;
            if (we) begin
                exp_be[t][ln] = 1'b1;
                exp_wd[t][8*ln +: 8] = data[8*i +: 8];
            end else begin
                wv = get_word(exp_addr[t]);
                exp_rd[8*i +: 8] = wv[8*ln +: 8];
            end
        end
        exp_cycles = 2;
        if (valid) exp_cycles = 2 + (w0 + 1) + ((exp_n == 2) ? (w1 + 1) : 0);

        @(negedge clk);
        unit_sel = UNIT_SEL_MEM;
        unit_in[0] = ctrl; unit_in[1] = addr; unit_in[2] = data;
        #1;
        total++;
        if (unit_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_in_idle_sel got=%b want=0", name, unit_ready);
        end

        cyc = 1; nobs = 0; waitcnt = -1; done = 1'b0;
        s_addr = '0; s_be = '0; s_wd = '0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            unit_in[0] = $urandom; unit_in[1] = $urandom; unit_in[2] = $urandom;
            if (unit_ready) begin
                done = 1'b1;
                got = unit_out;
            end else if (bus_req) begin
                if (waitcnt < 0) begin
                    waitcnt = (nobs == 0) ? w0 : w1;
                    s_addr = bus_addr; s_be = bus_be; s_wd = bus_wdata;
                end else begin
                    total++;
                    if (bus_addr !== s_addr || bus_be !== s_be || bus_wdata !== s_wd) begin
                        bad++;
                        $display("FAIL %s bus_stable got=%h/%h/%h want=%h/%h/%h", name,
                                 bus_addr, bus_be, bus_wdata, s_addr, s_be, s_wd);
                    end
                end
                if (waitcnt == 0) begin
                    bus_ack = 1'b1;
                    bus_rdata = bus_we ? $urandom : get_word(bus_addr);
                    if (nobs < 4) begin
                        obs_addr[nobs] = bus_addr; obs_we[nobs] = bus_we;
                        obs_be[nobs] = bus_be; obs_wd[nobs] = bus_wdata;
                    end
                    nobs++;
                    waitcnt = -1;
                end else begin
                    waitcnt--;
                end
            end
        end

        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout got=no_ready want=ready", name);
        end else begin
            total++;
            if (cyc != exp_cycles) begin
                bad++;
                $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_cycles);
            end
            total++;
            if (got !== exp_rd) begin
                bad++;
                $display("FAIL %s result got=%h want=%h", name, got, exp_rd);
            end
        end
        total++;
        if (nobs != exp_n) begin
            bad++;
            $display("FAIL %s txn_count got=%0d want=%0d", name, nobs, exp_n);
        end else begin
            for (int j = 0; j < exp_n; j++) begin
                bmask = {{8{exp_be[j][3]}}, {8{exp_be[j][2]}}, {8{exp_be[j][1]}}, {8{exp_be[j][0]}}};
                total++;
                if (obs_addr[j] !== exp_addr[j] || obs_we[j] !== we || obs_be[j] !== exp_be[j] ||
                    (we && ((obs_wd[j] & bmask) !== exp_wd[j]))) begin
                    bad++;
                    $display("FAIL %s txn%0d got=a%h we%b be%h wd%h want=a%h we%b be%h wd%h", name, j,
                             obs_addr[j], obs_we[j], obs_be[j], obs_wd[j] & bmask,
                             exp_addr[j], we, exp_be[j], exp_wd[j]);
                end
            end
        end

        // unit_sel still MEM through DONE: next cycle must be a plain IDLE, not a new access
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0 || unit_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s no_restart got=req%b rdy%b want=req0 rdy0", name, bus_req, unit_ready);
        end
        unit_sel = UNIT_SEL_NONE;

        if (valid && we) begin
            for (int j = 0; j < exp_n; j++) begin
                wv = get_word(exp_addr[j]);
                for (int b = 0; b < 4; b++)
                    if (exp_be[j][b]) wv[8*b +: 8] = exp_wd[j][8*b +: 8];
                mem[exp_addr[j]] = wv;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== '0 || bus_be !== '0 ||
            bus_wdata !== '0 || unit_out !== '0) begin
            bad++;
            $display("FAIL reset_values got=%b%b %h %h %h %h want=all0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, unit_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (unit_ready !== 1'b1 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got=rdy%b req%b want=rdy1 req0", unit_ready, bus_req);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (unit_ready !== 1'b1 || bus_req !== 1'b0) begin
                bad++;
                $display("FAIL idle cyc%0d got=rdy%b req%b want=rdy1 req0", i, unit_ready, bus_req);
            end
        end
    endtask

    task automatic test_directed();
        mem[30'h40] = 32'hCAFEBABE;
        do_access(MEM_CTRL_LW, 32'h100, 32'h0, 2, 0, "word_read");
        do_access(MEM_CTRL_SB, 32'h103, 32'h000000A5, 0, 0, "byte_write");
        mem[30'h80] = 32'h11223344;
        mem[30'h81] = 32'h55667788;
        do_access(MEM_CTRL_LH, 32'h203, 32'h0, 1, 1, "half_split_read");
        do_access(MEM_CTRL_SW, 32'h005, 32'hDDCCBBAA, 0, 2, "word_split_write");
        do_access(MEM_CTRL_LW, 32'h005, 32'h0, 0, 0, "read_after_write");
        do_access(MEM_CTRL_SH, 32'h00B, 32'hFFFF1234, 1, 0, "half_split_write");
    endtask

    task automatic test_undefined();
        do_access(32'd0, 32'h10, 32'h1, 0, 0, "undef_0");
        do_access(32'd7, 32'h13, 32'h2, 0, 0, "undef_7");
        do_access(32'hDEAD, 32'h20, 32'h3, 0, 0, "undef_dead");
    endtask

    task automatic test_wrap();
        do_access(MEM_CTRL_LW, 32'hFFFFFFFE, 32'h0, 0, 1, "wrap_read");
        do_access(MEM_CTRL_SH, 32'hFFFFFFFF, 32'h0000BEEF, 1, 0, "wrap_write");
    endtask

    task automatic test_back_to_back();
        word_t ctrls [7];
        word_t c, a;
        ctrls = '{MEM_CTRL_LB, MEM_CTRL_LH, MEM_CTRL_LW, MEM_CTRL_SB,
                  MEM_CTRL_SH, MEM_CTRL_SW, 32'd9};
        for (int i = 0; i < 40; i++) begin
            c = ctrls[$urandom_range(0, 6)];
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + $urandom_range(0, 7))
                                             : $urandom_range(0, 31);
            do_access(c, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid();
        mem[30'h10] = 32'h12345678;
        do_access(MEM_CTRL_LW, 32'h40, 32'h0, 0, 0, "pre_reset_read");
        @(negedge clk);
        unit_sel = UNIT_SEL_MEM;
        unit_in[0] = MEM_CTRL_LW; unit_in[1] = 32'h80; unit_in[2] = 32'h0;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_acc0 got=req%b want=req1", bus_req);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus_req !== 1'b0 || bus_addr !== '0 || unit_out !== '0) begin
            bad++;
            $display("FAIL rst_mid_clear got=req%b a%h out%h want=req0 a0 out0",
                     bus_req, bus_addr, unit_out);
        end
        unit_sel = UNIT_SEL_NONE;
        @(negedge clk);
        bus_ack = 1'b1;
        bus_rdata = 32'hA5A5A5A5;
        rst = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0 || unit_ready !== 1'b1 || unit_out !== '0) begin
            bad++;
            $display("FAIL rst_mid_after got=req%b rdy%b out%h want=req0 rdy1 out0",
                     bus_req, unit_ready, unit_out);
        end
        test_idle();
    endtask

    initial begin
        rst = 1'b0;
        unit_sel = UNIT_SEL_NONE;
        unit_in[0] = '0; unit_in[1] = '0; unit_in[2] = '0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_idle();
        test_directed();
        test_undefined();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        do_access(MEM_CTRL_LB, 32'h42, 32'h0, 0, 0, "post_reset_read");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
